// File: rtl/piso_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_pkg : state encoding and counter-width helper for the PISO serializer
// Revision : 1.0
// ----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_bit_prescaler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bit_prescaler : counts 0..BIT_CYCLES-1 while enabled, tick on terminal count
// Revision      : 1.0
// ----------------------------------------------------------------------------
module bit_prescaler
  import piso_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW     = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] C_TERM = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = enable && (cnt_q == C_TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_serializer : valid/ready loaded parallel-in serial-out transmitter
// Revision        : 1.0
// ----------------------------------------------------------------------------
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   BIT_CYCLES = 1,
  parameter logic MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             frame,
  output logic             done
);

  localparam int             BW     = cnt_width(WIDTH);
  localparam logic [BW-1:0]  C_LAST = BW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [BW-1:0]    bitcnt_q;
  logic             ser_q;
  logic             frame_q;
  logic             done_q;

  logic             bit_tick;
  logic             end_of_frame;
  logic             accept;
  logic             first_bit;
  logic             next_bit;

  assign end_of_frame = (state_q == ST_SHIFT) && bit_tick && (bitcnt_q == C_LAST);
  assign load_ready   = (state_q == ST_IDLE) || end_of_frame;
  assign accept       = load_valid && load_ready;

  bit_prescaler #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state_q == ST_SHIFT),
    .tick   (bit_tick)
  );

  // Rotate rather than shift so every register bit feeds the next state.
  if (MSB_FIRST) begin : g_msb_first
    assign sreg_d    = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
    assign first_bit = load_data[WIDTH-1];
    assign next_bit  = sreg_d[WIDTH-1];
  end else begin : g_lsb_first
    assign sreg_d    = {sreg_q[0], sreg_q[WIDTH-1:1]};
    assign first_bit = load_data[0];
    assign next_bit  = sreg_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      ser_q    <= IDLE_LEVEL;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= end_of_frame;
      if (accept) begin
        state_q  <= ST_SHIFT;
        sreg_q   <= load_data;
        bitcnt_q <= '0;
        ser_q    <= first_bit;
        frame_q  <= 1'b1;
      end else if (end_of_frame) begin
        state_q <= ST_IDLE;
        ser_q   <= IDLE_LEVEL;
        frame_q <= 1'b0;
      end else if ((state_q == ST_SHIFT) && bit_tick) begin
        sreg_q   <= sreg_d;
        bitcnt_q <= bitcnt_q + BW'(1);
        ser_q    <= next_bit;
      end
    end
  end

  assign ser_out = ser_q;
  assign frame   = frame_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_piso_serializer : directed bench over three parameterisations
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       lv_a, lv_b, lv_c;
  logic       rdy_a, so_a, fr_a, dn_a;
  logic       rdy_b, so_b, fr_b, dn_b;
  logic       rdy_c, so_c, fr_c, dn_c;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .load_data(data), .load_valid(lv_a),
    .load_ready(rdy_a), .ser_out(so_a), .frame(fr_a), .done(dn_a));

  piso_serializer #(.WIDTH(8), .BIT_CYCLES(2), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst), .load_data(data), .load_valid(lv_b),
    .load_ready(rdy_b), .ser_out(so_b), .frame(fr_b), .done(dn_b));

  piso_serializer #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_c (
    .clk(clk), .rst(rst), .load_data(data), .load_valid(lv_c),
    .load_ready(rdy_c), .ser_out(so_c), .frame(fr_c), .done(dn_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    rst  = 1'b1;
    data = 8'h00;
    lv_a = 1'b0;
    lv_b = 1'b0;
    lv_c = 1'b0;
    #2;
    check("rst_ready_a", 32'(rdy_a), 32'd1);
    check("rst_ser_a",   32'(so_a),  32'd0);
    check("rst_frame_a", 32'(fr_a),  32'd0);
    check("rst_done_a",  32'(dn_a),  32'd0);
    check("rst_ser_c",   32'(so_c),  32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic MSB-first frame of 0xA5
    pat  = 8'hA5;
    data = pat;
    lv_a = 1'b1;
    step();
    lv_a = 1'b0;
    data = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      check("a5_ser",   32'(so_a),  32'(pat[7-i]));
      check("a5_frame", 32'(fr_a),  32'd1);
      check("a5_ready", 32'(rdy_a), 32'(i == 7));
      check("a5_done",  32'(dn_a),  32'd0);
      step();
    end
    check("a5_done_pulse", 32'(dn_a), 32'd1);
    check("a5_end_ser",    32'(so_a), 32'd0);
    check("a5_end_frame",  32'(fr_a), 32'd0);
    step();
    check("a5_done_clear", 32'(dn_a), 32'd0);

    // LSB-first, two cycles per bit, 0x0F
    data = 8'h0F;
    lv_b = 1'b1;
    step();
    lv_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("0f_ser",   32'(so_b), 32'(i < 8));
      check("0f_frame", 32'(fr_b), 32'd1);
      check("0f_done",  32'(dn_b), 32'd0);
      step();
    end
    check("0f_done_pulse", 32'(dn_b), 32'd1);
    check("0f_end_frame",  32'(fr_b), 32'd0);
    step();
    check("0f_done_clear", 32'(dn_b), 32'd0);

    // Back-to-back 0xFF then 0x00
    data = 8'hFF;
    lv_a = 1'b1;
    step();
    lv_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("b2b_ser",   32'(so_a), 32'(i < 8));
      check("b2b_frame", 32'(fr_a), 32'd1);
      check("b2b_done",  32'(dn_a), 32'(i == 8));
      if (i == 7) begin
        check("b2b_ready", 32'(rdy_a), 32'd1);
        data = 8'h00;
        lv_a = 1'b1;
      end
      step();
      lv_a = 1'b0;
    end
    check("b2b_done2",     32'(dn_a), 32'd1);
    check("b2b_end_frame", 32'(fr_a), 32'd0);
    step();

    // Busy load of 0x3C during bit 3 of 0xA5 must be ignored
    pat  = 8'hA5;
    data = pat;
    lv_a = 1'b1;
    step();
    lv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy_ser",   32'(so_a), 32'(pat[7-i]));
      check("busy_frame", 32'(fr_a), 32'd1);
      if (i == 3) begin
        check("busy_ready", 32'(rdy_a), 32'd0);
        data = 8'h3C;
        lv_a = 1'b1;
      end
      step();
      lv_a = 1'b0;
    end
    check("busy_done",  32'(dn_a), 32'd1);
    check("busy_frame_end", 32'(fr_a), 32'd0);
    step();
    check("busy_no_second_frame", 32'(fr_a), 32'd0);
    check("busy_idle_ser",        32'(so_a), 32'd0);
    check("busy_idle_ready",      32'(rdy_a), 32'd1);

    // Asynchronous reset at bit 4 of 0xA5
    data = 8'hA5;
    lv_a = 1'b1;
    step();
    lv_a = 1'b0;
    step();
    step();
    step();
    step();
    check("mid_pre_ser", 32'(so_a), 32'(pat[3]));
    #2;
    rst = 1'b1;
    #1;
    check("arst_ser",   32'(so_a),  32'd0);
    check("arst_frame", 32'(fr_a),  32'd0);
    check("arst_ready", 32'(rdy_a), 32'd1);
    check("arst_done",  32'(dn_a),  32'd0);
    step();
    rst = 1'b0;
    step();
    check("arst_post_done",  32'(dn_a), 32'd0);
    check("arst_post_frame", 32'(fr_a), 32'd0);

    pat  = 8'h81;
    data = pat;
    lv_a = 1'b1;
    step();
    lv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("81_ser",   32'(so_a), 32'(pat[7-i]));
      check("81_frame", 32'(fr_a), 32'd1);
      step();
    end
    check("81_done", 32'(dn_a), 32'd1);

    // Idle-high line sending 0x00
    check("c_idle_ser", 32'(so_c), 32'd1);
    data = 8'h00;
    lv_c = 1'b1;
    step();
    lv_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("c_ser",   32'(so_c), 32'd0);
      check("c_frame", 32'(fr_c), 32'd1);
      step();
    end
    check("c_done",     32'(dn_c), 32'd1);
    check("c_end_ser",  32'(so_c), 32'd1);
    step();
    check("c_done_clear", 32'(dn_c), 32'd0);
    check("c_idle_ser2",  32'(so_c), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
